mmio_uart_tx: RTL

Memory-mapped UART transmitter on the single-cycle CPU's data bus, downstream of the core's store port. Decodes `MemWrite`/`Mem_WrAddr`/`Mem_WrData` stores into a small register window, buffers bytes in a TX FIFO, and serialises them as 8N1 on `tx`. Returns status combinationally on `rd_data` so the core's `ReadData` mux can use it in the same cycle.

---
 rtl/uart_pkg.sv | 27 ++
 rtl/sync_fifo.sv | 48 ++++
 rtl/mmio_uart_tx.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared register offsets, STATUS bit positions and transmit FSM states
// for the memory-mapped UART transmitter.
package uart_pkg;

  localparam logic [31:0] TXDATA_OFF = 32'd0;
  localparam logic [31:0] STATUS_OFF = 32'd4;
  localparam logic [31:0] CLKDIV_OFF = 32'd8;
  localparam logic [31:0] WINDOW_BYTES = 32'd12;

  localparam int ST_EMPTY = 0;
  localparam int ST_FULL  = 1;
  localparam int ST_BUSY  = 2;
  localparam int ST_OVF   = 3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } tx_state_e;

  // A zero divisor would stall the baud counter, so it is promoted to 1.
  function automatic logic [15:0] div_sanitize(input logic [15:0] v);
    return (v == 16'd0) ? 16'd1 : v;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a combinational head read; pointers carry one
// extra wrap bit so full and empty are distinguishable.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;
  logic             do_push;
  logic             do_pop;

  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop_data = mem_q[rd_ptr_q[AW-1:0]];

  // A push into a full FIFO is still accepted when the head leaves this cycle.
  assign do_push = push & (~full | pop);
  assign do_pop  = pop & ~empty;

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// UART transmitter mapped into the core's data bus: register window decode,
// combinational status read-back, TX FIFO and 8N1 serialiser.
module mmio_uart_tx
  import uart_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_F000,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [15:0] DIV_RESET  = 16'd434
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic [31:0] Mem_WrAddr,
  input  logic [31:0] Mem_WrData,
  output logic        sel,
  output logic [31:0] rd_data,
  output logic        tx
);

  logic [31:0] addr_word;
  logic [31:0] off;
  logic        wr_txdata;
  logic        wr_status;
  logic        wr_clkdiv;

  logic [15:0] clkdiv_q, clkdiv_d;
  logic        ovf_q, ovf_d;

  tx_state_e   state_q;
  logic [15:0] cnt_q;
  logic [7:0]  shift_q;
  logic [2:0]  bit_idx_q;
  logic        tx_q;

  logic        fifo_full;
  logic        fifo_empty;
  logic [7:0]  fifo_data;
  logic        at_boundary;
  logic        pop;
  logic [31:0] status;
  logic        unused_bits;

  assign addr_word = {Mem_WrAddr[31:2], 2'b00};
  assign off       = addr_word - BASE_ADDR;
  assign sel       = (addr_word >= BASE_ADDR) && (off < WINDOW_BYTES);

  assign wr_txdata = MemWrite & sel & (off == TXDATA_OFF);
  assign wr_status = MemWrite & sel & (off == STATUS_OFF);
  assign wr_clkdiv = MemWrite & sel & (off == CLKDIV_OFF);

  assign unused_bits = ^{Mem_WrAddr[1:0], Mem_WrData[31:16]};

  assign at_boundary = (cnt_q == 16'd1);
  assign pop = ~fifo_empty &
               ((state_q == S_IDLE) || ((state_q == S_STOP) && at_boundary));

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (wr_txdata),
    .push_data (Mem_WrData[7:0]),
    .pop       (pop),
    .pop_data  (fifo_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_comb begin
    clkdiv_d = clkdiv_q;
    if (wr_clkdiv) clkdiv_d = div_sanitize(Mem_WrData[15:0]);
  end

  always_comb begin
    ovf_d = ovf_q;
    if (wr_status) ovf_d = 1'b0;
    if (wr_txdata && fifo_full && !pop) ovf_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      clkdiv_q <= DIV_RESET;
      ovf_q    <= 1'b0;
    end else begin
      clkdiv_q <= clkdiv_d;
      ovf_q    <= ovf_d;
    end
  end

  // The reload always uses clkdiv_q, so a divisor store lands at the next bit edge.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= DIV_RESET;
      shift_q   <= 8'd0;
      bit_idx_q <= 3'd0;
      tx_q      <= 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (pop) begin
            shift_q <= fifo_data;
            cnt_q   <= clkdiv_q;
            tx_q    <= 1'b0;
            state_q <= S_START;
          end
        end
        S_START: begin
          if (at_boundary) begin
            cnt_q     <= clkdiv_q;
            bit_idx_q <= 3'd0;
            tx_q      <= shift_q[0];
            state_q   <= S_DATA;
          end else begin
            cnt_q <= cnt_q - 16'd1;
          end
        end
        S_DATA: begin
          if (at_boundary) begin
            cnt_q <= clkdiv_q;
            if (bit_idx_q == 3'd7) begin
              tx_q    <= 1'b1;
              state_q <= S_STOP;
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
              tx_q      <= shift_q[bit_idx_q + 3'd1];
            end
          end else begin
            cnt_q <= cnt_q - 16'd1;
          end
        end
        S_STOP: begin
          if (at_boundary) begin
            if (pop) begin
              shift_q <= fifo_data;
              cnt_q   <= clkdiv_q;
              tx_q    <= 1'b0;
              state_q <= S_START;
            end else begin
              state_q <= S_IDLE;
            end
          end else begin
            cnt_q <= cnt_q - 16'd1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          tx_q    <= 1'b1;
        end
      endcase
    end
  end

  assign tx = tx_q;

  always_comb begin
    status            = 32'd0;
    status[ST_EMPTY]  = fifo_empty;
    status[ST_FULL]   = fifo_full;
    status[ST_BUSY]   = (state_q != S_IDLE);
    status[ST_OVF]    = ovf_q;
  end

  always_comb begin
    rd_data = 32'd0;
    if (sel) begin
      case (off)
        STATUS_OFF: rd_data = status;
        CLKDIV_OFF: rd_data = {16'd0, clkdiv_q};
        default:    rd_data = 32'd0;
      endcase
    end
  end

endmodule
